// File: rtl/led_catcher_pkg.sv
// Shared types and helpers for the LED catcher game core.
// Supports up to MAX_LEDS LED positions.
package led_catcher_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLASH, OVER} state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MAX_LEDS = 64;
  localparam int OH_W     = $clog2(MAX_LEDS);

  // Callers truncate the result to their own LED count.
  function automatic logic [MAX_LEDS-1:0] onehot(input logic [OH_W-1:0] idx);
    return {{(MAX_LEDS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Produces a single-cycle pulse in the clk_in domain.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/led_catcher_engine.sv
// LED catcher game core: a bouncing one-hot LED, a catch button, score/miss keeping.
// Outputs are registered and reflect the state after each clock edge.
module led_catcher_engine
  import led_catcher_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int TARGET_IDX   = 7,
  parameter int START_PERIOD = 4,
  parameter int MIN_PERIOD   = 1,
  parameter int FLASH_TICKS  = 2,
  parameter int MAX_MISSES   = 3,
  parameter int SCORE_W      = 8
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic                            tick_in,
  input  logic                            btn_in,
  input  logic                            start_in,
  output logic [NUM_LEDS-1:0]             led,
  output logic [SCORE_W-1:0]              score,
  output logic [$clog2(MAX_MISSES+1)-1:0] misses,
  output logic                            game_over,
  output logic                            hit_pulse
);

  localparam int POS_W   = $clog2(NUM_LEDS);
  localparam int CNT_MAX = (START_PERIOD > FLASH_TICKS) ? START_PERIOD : FLASH_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int MISS_W  = $clog2(MAX_MISSES + 1);

  localparam logic [POS_W-1:0]   LAST_POS   = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]   TARGET     = POS_W'(TARGET_IDX);
  localparam logic [CNT_W-1:0]   START_P    = CNT_W'(START_PERIOD);
  localparam logic [CNT_W-1:0]   MIN_P      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   FLASH_LAST = CNT_W'(FLASH_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

  logic tick_e, btn_e, start_e;

  sync_edge_detect u_tick  (.clk_in(clk_in), .rst(rst), .async_in(tick_in),  .pulse(tick_e));
  sync_edge_detect u_btn   (.clk_in(clk_in), .rst(rst), .async_in(btn_in),   .pulse(btn_e));
  sync_edge_detect u_start (.clk_in(clk_in), .rst(rst), .async_in(start_in), .pulse(start_e));

  state_t               state, state_n;
  logic [POS_W-1:0]     pos, pos_n;
  logic                 dir, dir_n;
  logic [CNT_W-1:0]     period, period_n;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_n;
  logic [SCORE_W-1:0]   score_n;
  logic [MISS_W-1:0]    misses_n;
  logic [NUM_LEDS-1:0]  led_n;
  logic                 game_over_n, hit_n;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos       <= '0;
      dir       <= DIR_UP;
      period    <= START_P;
      tick_cnt  <= '0;
      score     <= '0;
      misses    <= '0;
      led       <= '0;
      game_over <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      dir       <= dir_n;
      period    <= period_n;
      tick_cnt  <= tick_cnt_n;
      score     <= score_n;
      misses    <= misses_n;
      led       <= led_n;
      game_over <= game_over_n;
      hit_pulse <= hit_n;
    end
  end

  // A button press is judged against the pre-step position; a hit discards any step due this cycle.
  always_comb begin
    state_n    = state;
    pos_n      = pos;
    dir_n      = dir;
    period_n   = period;
    tick_cnt_n = tick_cnt;
    score_n    = score;
    misses_n   = misses;
    hit_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start_e) begin
          pos_n      = '0;
          dir_n      = DIR_UP;
          tick_cnt_n = '0;
          period_n   = START_P;
          state_n    = RUN;
        end
      end
      RUN: begin
        if (tick_e) begin
          if (tick_cnt == period - 1'b1) begin
            tick_cnt_n = '0;
            if (dir == DIR_UP) begin
              pos_n = pos + 1'b1;
              if (pos_n == LAST_POS) dir_n = DIR_DOWN;
            end else begin
              pos_n = pos - 1'b1;
              if (pos_n == '0) dir_n = DIR_UP;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
        if (btn_e) begin
          if (pos == TARGET) begin
            hit_n      = 1'b1;
            score_n    = (score == SCORE_MAX) ? score : score + 1'b1;
            period_n   = (period > MIN_P) ? period - 1'b1 : MIN_P;
            tick_cnt_n = '0;
            pos_n      = pos;
            dir_n      = dir;
            state_n    = FLASH;
          end else begin
            misses_n = misses + 1'b1;
            if (misses_n == MISS_LIMIT) state_n = OVER;
          end
        end
      end
      FLASH: begin
        if (tick_e) begin
          if (tick_cnt == FLASH_LAST) begin
            tick_cnt_n = '0;
            state_n    = RUN;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      OVER: begin
        if (start_e) begin
          score_n    = '0;
          misses_n   = '0;
          period_n   = START_P;
          pos_n      = '0;
          dir_n      = DIR_UP;
          tick_cnt_n = '0;
          state_n    = RUN;
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      IDLE:    led_n = '0;
      FLASH:   led_n = '1;
      default: led_n = NUM_LEDS'(onehot(OH_W'(pos_n)));
    endcase
    game_over_n = (state_n == OVER);
  end

endmodule

// File: tb/tb_led_catcher_engine.sv
// Directed bench for led_catcher_engine: one default-parameter instance and one
// narrow-score instance (SCORE_W=2, START_PERIOD=2) exercised by hand-computed steps.
module tb_led_catcher_engine;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  logic       tick_a = 1'b0, btn_a = 1'b0, start_a = 1'b0;
  logic [7:0] led_a, score_a;
  logic [1:0] misses_a;
  logic       over_a, hit_a;

  logic       tick_b = 1'b0, btn_b = 1'b0, start_b = 1'b0;
  logic [7:0] led_b;
  logic [1:0] score_b, misses_b;
  logic       over_b, hit_b;

  int checks    = 0;
  int errors    = 0;
  int hit_cnt_a = 0;
  int hit_cnt_b = 0;
  int bounce_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
  int score_exp  [5]  = '{1, 2, 3, 3, 3};

  led_catcher_engine dut_a (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_a), .btn_in(btn_a), .start_in(start_a),
    .led(led_a), .score(score_a), .misses(misses_a), .game_over(over_a), .hit_pulse(hit_a)
  );

  led_catcher_engine #(.START_PERIOD(2), .SCORE_W(2)) dut_b (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_b), .btn_in(btn_b), .start_in(start_b),
    .led(led_b), .score(score_b), .misses(misses_b), .game_over(over_b), .hit_pulse(hit_b)
  );

  always #5 clk_in = ~clk_in;

  // Every high cycle of hit_pulse is counted, so a stretched pulse shows up as an extra hit.
  always @(negedge clk_in) begin
    if (hit_a === 1'b1) hit_cnt_a++;
    if (hit_b === 1'b1) hit_cnt_b++;
  end

  task automatic applyStimulus(input bit on_b, input bit t, input bit b, input bit s);
    @(negedge clk_in);
    if (on_b) begin
      tick_b = t; btn_b = b; start_b = s;
    end else begin
      tick_a = t; btn_a = b; start_a = s;
    end
    repeat (4) @(negedge clk_in);
    tick_a = 1'b0; btn_a = 1'b0; start_a = 1'b0;
    tick_b = 1'b0; btn_b = 1'b0; start_b = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic ticks(input bit on_b, input int n);
    repeat (n) applyStimulus(on_b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    checkOutput("reset_led",    led_a,    32'h00);
    checkOutput("reset_score",  score_a,  32'h0);
    checkOutput("reset_misses", misses_a, 32'h0);
    checkOutput("reset_over",   over_a,   32'h0);
    checkOutput("reset_hit",    hit_a,    32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    $display("[TB] instance A: start, stepping, simultaneous hit");
    applyStimulus(0, 0, 0, 1);
    checkOutput("start_led", led_a, 32'h01);
    ticks(0, 3);
    checkOutput("period4_hold", led_a, 32'h01);
    ticks(0, 1);
    checkOutput("first_step", led_a, 32'h02);
    ticks(0, 24);
    checkOutput("reach_end", led_a, 32'h80);
    ticks(0, 3);
    checkOutput("step_due_hold", led_a, 32'h80);
    applyStimulus(0, 1, 1, 0);
    checkOutput("sim_hit_flash", led_a, 32'hFF);
    checkOutput("sim_hit_score", score_a, 32'h1);
    checkOutput("hit_pulse_count_a", hit_cnt_a, 32'd1);
    checkOutput("hit_pulse_low", hit_a, 32'h0);
    ticks(0, 1);
    checkOutput("flash_tick1", led_a, 32'hFF);
    ticks(0, 1);
    checkOutput("flash_exit_pos", led_a, 32'h80);
    ticks(0, 2);
    checkOutput("period3_hold", led_a, 32'h80);
    ticks(0, 1);
    checkOutput("period3_step", led_a, 32'h40);

    $display("[TB] instance A: misses and game over");
    ticks(0, 2);
    applyStimulus(0, 1, 1, 0);
    checkOutput("sim_miss_step", led_a, 32'h20);
    checkOutput("miss1", misses_a, 32'h1);
    checkOutput("miss1_not_over", over_a, 32'h0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("miss2", misses_a, 32'h2);
    checkOutput("miss2_no_step", led_a, 32'h20);
    applyStimulus(0, 0, 1, 0);
    checkOutput("miss3", misses_a, 32'h3);
    checkOutput("over_set", over_a, 32'h1);
    ticks(0, 1);
    checkOutput("over_frozen", led_a, 32'h20);
    applyStimulus(0, 0, 0, 1);
    checkOutput("restart_over", over_a, 32'h0);
    checkOutput("restart_score", score_a, 32'h0);
    checkOutput("restart_misses", misses_a, 32'h0);
    checkOutput("restart_led", led_a, 32'h01);
    ticks(0, 3);
    checkOutput("restart_period_hold", led_a, 32'h01);
    ticks(0, 1);
    checkOutput("restart_period_step", led_a, 32'h02);
    applyStimulus(0, 0, 0, 1);
    checkOutput("start_ignored_run", led_a, 32'h02);
    applyStimulus(0, 0, 1, 0);
    checkOutput("miss_after_restart", misses_a, 32'h1);

    $display("[TB] instance B: ping-pong, score saturation, period floor");
    applyStimulus(1, 0, 0, 1);
    checkOutput("b_start_led", led_b, 32'h01);
    ticks(1, 1);
    checkOutput("b_period2_hold", led_b, 32'h01);
    ticks(1, 1);
    checkOutput("b_bounce_0", led_b, 32'(1) << bounce_exp[0]);
    for (int i = 1; i < 16; i++) begin
      ticks(1, 2);
      checkOutput($sformatf("b_bounce_%0d", i), led_b, 32'(1) << bounce_exp[i]);
    end
    ticks(1, 10);
    checkOutput("b_reach_end", led_b, 32'h80);
    for (int h = 0; h < 5; h++) begin
      applyStimulus(1, 0, 1, 0);
      checkOutput($sformatf("b_score_hit%0d", h + 1), score_b, 32'(score_exp[h]));
      if (h == 0) checkOutput("b_flash_led", led_b, 32'hFF);
      ticks(1, 2);
    end
    checkOutput("hit_pulse_count_b", hit_cnt_b, 32'd5);
    checkOutput("b_pos_kept", led_b, 32'h80);
    ticks(1, 1);
    checkOutput("b_period_floor", led_b, 32'h40);

    $display("[TB] asynchronous reset mid-game");
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_led_a",    led_a,    32'h00);
    checkOutput("async_rst_misses_a", misses_a, 32'h0);
    checkOutput("async_rst_score_b",  score_b,  32'h0);
    checkOutput("async_rst_led_b",    led_b,    32'h00);
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    ticks(0, 1);
    checkOutput("idle_after_reset", led_a, 32'h00);
    applyStimulus(0, 0, 1, 0);
    checkOutput("idle_btn_ignored", misses_a, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
